// File: rtl/tiny_cpu_core_if.sv
// Instruction-fetch and data-memory bus of tiny_cpu_core.
// master = core side, slave = ROM/data-memory side.
interface tiny_cpu_core_if #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 3,
  parameter int PC_W   = 3
);
  localparam int IW = 6 + 3 * REG_AW;

  logic [PC_W-1:0]   i_addr;
  logic [IW-1:0]     i_data;
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  modport master (
    output i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_data, d_rdata, d_ack
  );

  modport slave (
    input  i_addr, d_req, d_we, d_addr, d_wdata,
    output i_data, d_rdata, d_ack
  );
endinterface

// File: rtl/tiny_cpu_core.sv
// Multi-cycle parametrised CPU core: FETCH/EXEC/MEM(/HALT) FSM, req/ack data bus, GPO.
// Optional halt instruction enabled by defining TINY_CPU_HALT_EN.
module tiny_cpu_core #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 3,
  parameter int PC_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  tiny_cpu_core_if.master     bus,
  output logic [DATA_W-1:0]   gpo,
  output logic                halted
);
  localparam int          IW   = 6 + 3 * REG_AW;
  localparam int unsigned NREG = 2 ** REG_AW;

`ifdef TINY_CPU_HALT_EN
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;
`endif

  typedef enum logic [2:0] {
    T_ALU, T_LOAD, T_STORE, T_IMM, T_JUMP, T_CJUMP, T_HALT, T_NOP
  } op_t;

  typedef enum logic [2:0] {
    F_ADD, F_AND, F_OR, F_XOR, F_NOT, F_EQ, F_LT, F_SHL1
  } func_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [IW-1:0]     r_ir;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_gpo;
  logic              r_d_req;
  logic              r_d_we;
  logic [DATA_W-1:0] r_d_addr;
  logic [DATA_W-1:0] r_d_wdata;
  logic              r_halted;

  op_t               w_type;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rs1;
  func_t             w_func;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] w_alu;
  logic [PC_W-1:0]   w_pc_inc;
  logic              w_gpo_store;

  assign w_type   = op_t'(r_ir[IW-1 -: 3]);
  assign w_rd     = r_ir[IW-4 -: REG_AW];
  assign w_rs2    = r_ir[3+2*REG_AW-1 -: REG_AW];
  assign w_rs1    = r_ir[3+REG_AW-1 -: REG_AW];
  assign w_func   = func_t'(r_ir[2:0]);

  // Asynchronous reads; a same-cycle write lands on the edge, so reads see the old value.
  assign w_a      = r_regs[w_rs1];
  assign w_b      = r_regs[w_rs2];
  assign w_d      = r_regs[w_rd];
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_gpo_store = (w_type == T_STORE) && (w_d == '1);

  always_comb begin
    w_alu = '0;
    unique case (w_func)
      F_ADD:  w_alu = w_a + w_b;
      F_AND:  w_alu = w_a & w_b;
      F_OR:   w_alu = w_a | w_b;
      F_XOR:  w_alu = w_a ^ w_b;
      F_NOT:  w_alu = ~w_a;
      F_EQ:   w_alu = DATA_W'(w_a == w_b);
      F_LT:   w_alu = DATA_W'(w_a < w_b);
      F_SHL1: w_alu = w_a << 1;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_gpo     <= '0;
      r_d_req   <= 1'b0;
      r_d_we    <= 1'b0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_halted  <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (en) begin
            r_ir    <= bus.i_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          unique case (w_type)
            T_ALU: begin
              r_regs[w_rd] <= w_alu;
              r_pc         <= w_pc_inc;
            end
            T_IMM: begin
              r_regs[w_rd] <= r_ir[DATA_W-1:0];
              r_pc         <= w_pc_inc;
            end
            T_JUMP:  r_pc <= w_a[PC_W-1:0];
            T_CJUMP: r_pc <= w_b[0] ? w_a[PC_W-1:0] : w_pc_inc;
            T_LOAD, T_STORE: begin
              if (w_gpo_store) begin
                r_gpo <= w_a;
                r_pc  <= w_pc_inc;
              end else begin
                r_d_req   <= 1'b1;
                r_d_we    <= (w_type == T_STORE);
                r_d_addr  <= (w_type == T_STORE) ? w_d : w_a;
                r_d_wdata <= w_a;
                r_state   <= S_MEM;
              end
            end
`ifdef TINY_CPU_HALT_EN
            T_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
`endif
            default: r_pc <= w_pc_inc;
          endcase
        end
        S_MEM: begin
          if (bus.d_ack) begin
            if (!r_d_we) r_regs[w_rd] <= bus.d_rdata;
            r_d_req <= 1'b0;
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
`ifdef TINY_CPU_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.i_addr  = r_pc;
  assign bus.d_req   = r_d_req;
  assign bus.d_we    = r_d_we;
  assign bus.d_addr  = r_d_addr;
  assign bus.d_wdata = r_d_wdata;
  assign gpo         = r_gpo;

`ifdef TINY_CPU_HALT_EN
  assign halted = r_halted;
`else
  assign halted = 1'b0;
  logic w_unused_halted;
  assign w_unused_halted = r_halted;
`endif
endmodule

// File: doc/tiny_cpu_core.md
# tiny_cpu_core

Parametrised multi-cycle successor to the 4-bit SoC CPU. It keeps the same instruction classes and adds several capabilities:
- configurable data width, register count and PC width;
- a working conditional jump;
- a `d_req`/`d_ack` data-memory handshake with wait states;
- a memory-mapped GPO register;
- an optional halt instruction.

It sits between the instruction-ROM loader (which drives `en`) and the data memory.

## Interface
Parameters:
- `DATA_W`, 4, datapath and register width; must be ≥ `PC_W`.
- `REG_AW`, 3, register-address width; register file holds 2^`REG_AW` entries.
- `PC_W`, 3, program-counter width; instruction space is 2^`PC_W` words.
- `IW`, 3+3*`REG_AW`+3 (derived), instruction width; `DATA_W` ≤ 3+2*`REG_AW` is required.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `en` in 1: run enable; gates the exit from FETCH only.
- `i_addr` out `PC_W`: instruction address, equal to `pc`.
- `i_data` in `IW`: instruction word, valid in the same cycle as `i_addr`.
- `d_req` out 1: data access request, registered.
- `d_we` out 1: 1 = store, 0 = load; valid while `d_req`.
- `d_addr` out `DATA_W`: data address, taken from [rs1] for a load and from [rd] for a store.
- `d_wdata` out `DATA_W`: store data, taken from [rs1].
- `d_rdata` in `DATA_W`: load data, sampled in the cycle `d_ack` is high.
- `d_ack` in 1: access complete; may be high in the first `d_req` cycle.
- `gpo` out `DATA_W`: general-purpose output register.
- `halted` out 1: core is in HALT.

## Operation
Instruction fields:
- Layout is [type 3][rd][rs2][rs1][func 3].
- Types: 000 ALU, 001 LOAD, 010 STORE, 011 IMM, 100 JUMP, 101 CJUMP, 110 HALT, 111 NOP.

ALU functions (write rd):
- 000 ADD, modulo 2^`DATA_W`.
- 001 AND, 010 OR, 011 XOR.
- 100 NOT [rs1].
- 101 EQ, zero-extended 1/0.
- 110 LT, unsigned, zero-extended.
- 111 SHL1, zero fill.

Other instructions:
- IMM: rd ← low `DATA_W` bits of {rs2,rs1,func}.
- JUMP: pc ← [rs1][`PC_W`-1:0].
- CJUMP: if [rs2][0] = 1, pc ← [rs1][`PC_W`-1:0]; otherwise pc+1.
- STORE to address all-ones: updates `gpo` ← [rs1] and issues no bus access.
- All other LOAD/STORE go through the MEM state.
- pc+1 wraps modulo 2^`PC_W`.

FSM states: FETCH, EXEC, MEM, HALT.
- FETCH: if `en`, latch `i_data` into the instruction register and go to EXEC; else stay.
- EXEC:
  - ALU, IMM, NOP and GPO store: perform the register/`gpo` write, pc+1, go to FETCH.
  - JUMP/CJUMP: update pc, go to FETCH.
  - LOAD/STORE (non-GPO): latch `d_addr`/`d_wdata`/`d_we`, set `d_req`=1, go to MEM.
  - HALT: go to HALT.
- MEM: hold `d_req` and all bus outputs stable until `d_ack`. In the ack cycle:
  - LOAD writes rd ← `d_rdata`;
  - `d_req` clears on the next edge;
  - pc+1, go to FETCH.
- HALT: absorbing state; only `rst` leaves it. `halted` = 1 while in HALT.

Register file and bus rules:
- Register file: 2 asynchronous read ports, 1 write port.
- A write and a read of the same register in one cycle returns the old value.
- `d_ack` outside MEM is ignored.

## Timing
- Reset values:
  - `pc` = 0, state = FETCH;
  - all registers = 0, `gpo` = 0;
  - `d_req` = 0, `d_we` = 0, `d_addr` = 0, `d_wdata` = 0, `halted` = 0.
- `rst` mid-MEM aborts the access: `d_req` = 0 on the next edge and no register write occurs.
- Cycles per instruction:
  - 2 for ALU, IMM, JUMP, CJUMP, NOP and GPO store;
  - 3+N for a bus LOAD/STORE, where N = number of `d_req` cycles with `d_ack` = 0.
- `en` low during EXEC or MEM does not stall; the current instruction completes.
- `en` low in FETCH inserts bubbles; `i_addr` stays stable.
- `gpo` changes on the edge ending the EXEC cycle of the store.

## Configuration
- `TINY_CPU_HALT_EN` defined:
  - type 110 enters HALT;
  - `halted` is functional.
- `TINY_CPU_HALT_EN` not defined:
  - type 110 executes as NOP (pc+1, 2 cycles);
  - the HALT state is not built;
  - `halted` is tied to 0.

## Test plan
All scenarios use default parameters.
- **ADD wrap:** IMM r1=9; IMM r2=8; ADD r3=r1+r2 → r3=1. Each instruction takes 2 cycles; pc=3 after 6 cycles with `en`=1.
- **Load wait states:** r1=5, LOAD r2←[r1], `d_ack` delayed 3 cycles with `d_rdata`=0xA → `d_req` high for exactly 4 cycles with `d_addr`=5 and `d_we`=0; r2=0xA; instruction takes 6 cycles.
- **GPO store:** IMM r1=0xF; IMM r4=0x6; STORE [r1]←r4 → `gpo`=6, `d_req` never asserted. STORE to r1=2 instead → `d_req`=1, `d_we`=1, `d_addr`=2, `d_wdata`=6.
- **Conditional jump:** r2=1, r1=6, CJUMP → pc=6. With r2=2 → pc=prev+1. JUMP with r1=0xE → pc=6 (truncated).
- **Halt (`TINY_CPU_HALT_EN`):** HALT at pc=3 → `halted`=1 and pc frozen for 20 cycles. Without the macro → pc advances to 4.
- **Reset mid-MEM:** assert `rst` during the second `d_req` cycle of a LOAD → next edge `d_req`=0, pc=0, target register=0; late `d_ack` is ignored.
